// File: rtl/led_pkg.sv
// Purpose: shared types and defaults for the LED serial header drivers.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package led_pkg;

  // Defaults shared with the display top levels that instantiate the driver.
  localparam int LED_WIDTH_DEF   = 16;
  localparam int LED_CLK_DIV_DEF = 4;

  // Serializer frame states: IDLE waits for a request, LOW/HIGH are the two
  // halves of one serial clock period, DONE is the one-cycle completion slot.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2,
    DONE = 2'd3
  } led_p2s_state_t;

endpackage

// File: rtl/led_phase_timer.sv
// Purpose: counts CLK_DIV system clocks per serial-clock phase; reused for LOW and HIGH.
// Latency: expire is high in the CLK_DIV-th cycle after restart drops (combinational from the counter).
// Backpressure: none; free-running while restart is low.
//
// Ports:
//   clk     - system clock
//   rst     - synchronous active-high reset
//   restart - holds the counter at zero (used while no frame is in progress)
//   expire  - last cycle of the current phase
module led_phase_timer
  import led_pkg::*;
#(
  parameter int CLK_DIV = LED_CLK_DIV_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic expire
);

  localparam int CW = $clog2(CLK_DIV + 1);
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] div_cnt;

  // The counter wraps to zero on expiry, so a phase change needs no explicit
  // restart: the next phase starts counting from zero automatically.
  always_ff @(posedge clk) begin
    if (rst || restart || expire) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + CW'(1);
    end
  end

  assign expire = (div_cnt == LAST);

endmodule

// File: rtl/led_p2s_driver.sv
// Purpose: parallel-to-serial driver for daisy-chained 74HC595-style LED shift registers.
// Latency: first led_clk fall one cycle after the start edge; frame = WIDTH*2*CLK_DIV busy cycles + 1 done cycle.
// Backpressure: start is ignored while busy or in DONE (no queuing); auto_en chains frames with one idle cycle.
//
// Ports:
//   clk, rst        - system clock, synchronous active-high reset
//   start, auto_en  - one-shot frame request / continuous refresh request
//   data[WIDTH]     - pattern, captured into a shadow copy at frame start
//   led_clk/led_dat - serial clock (idles high) and data to the shift register
//   led_clr/led_en  - active-low clear and output enable to the shift register
//   busy, done      - frame in progress / one-cycle completion pulse
module led_p2s_driver
  import led_pkg::*;
#(
  parameter int WIDTH      = LED_WIDTH_DEF,
  parameter int CLK_DIV    = LED_CLK_DIV_DEF,
  parameter bit MSB_FIRST  = 1'b1,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             auto_en,
  input  logic [WIDTH-1:0] data,
  output logic             led_clk,
  output logic             led_dat,
  output logic             led_clr,
  output logic             led_en,
  output logic             busy,
  output logic             done
);

  localparam int BW = $clog2(WIDTH + 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

  led_p2s_state_t state, state_nxt;

  logic [WIDTH-1:0] shadow, shadow_nxt;
  logic [BW-1:0]    bit_cnt, bit_cnt_nxt;
  logic             dat_nxt;
  logic             load;
  logic             restart;
  logic             expire;

  // The bit on the wire is always taken from the same end of the shadow
  // register; the register is shifted towards that end after each bit.
  function automatic logic pin_bit(input logic [WIDTH-1:0] s);
    return (MSB_FIRST ? s[WIDTH-1] : s[0]) ^ ACTIVE_LOW;
  endfunction

  function automatic logic [WIDTH-1:0] shift_out(input logic [WIDTH-1:0] s);
    return MSB_FIRST ? (s << 1) : (s >> 1);
  endfunction

  // Timer is held at zero outside LOW/HIGH so each frame's first LOW phase
  // is a full CLK_DIV cycles long.
  assign restart = (state == IDLE) || (state == DONE);

  led_phase_timer #(
    .CLK_DIV(CLK_DIV)
  ) u_phase_timer (
    .clk    (clk),
    .rst    (rst),
    .restart(restart),
    .expire (expire)
  );

  // A frame starts from IDLE on any request; from DONE only auto_en counts,
  // so a start pulse landing in DONE is dropped rather than queued.
  assign load = ((state == IDLE) && (start || auto_en)) ||
                ((state == DONE) && auto_en);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    shadow_nxt  = shadow;
    bit_cnt_nxt = bit_cnt;
    dat_nxt     = led_dat;

    if (load) begin
      state_nxt   = LOW;
      shadow_nxt  = data;
      bit_cnt_nxt = '0;
      dat_nxt     = pin_bit(data);
    end else begin
      unique case (state)
        IDLE: state_nxt = IDLE;
        LOW: begin
          if (expire) begin
            state_nxt = HIGH;
          end
        end
        HIGH: begin
          if (expire) begin
            if (bit_cnt == BIT_LAST) begin
              state_nxt = DONE;
            end else begin
              state_nxt   = LOW;
              bit_cnt_nxt = bit_cnt + BW'(1);
              shadow_nxt  = shift_out(shadow);
              dat_nxt     = pin_bit(shift_out(shadow));
            end
          end
        end
        DONE:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Outputs are registered from the next state so they line up with the
  // state register: led_clk is low exactly while the FSM sits in LOW.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow  <= '0;
      bit_cnt <= '0;
      led_clk <= 1'b1;
      led_dat <= 1'b0;
      led_clr <= 1'b0;
      led_en  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      shadow  <= shadow_nxt;
      bit_cnt <= bit_cnt_nxt;
      led_clk <= (state_nxt != LOW);
      led_dat <= dat_nxt;
      led_clr <= 1'b1;
      led_en  <= 1'b1;
      busy    <= (state_nxt == LOW) || (state_nxt == HIGH);
      done    <= (state_nxt == DONE);
    end
  end

endmodule

// File: doc/led_p2s_driver.md
Name: led_p2s_driver

Overview:
Parametrised parallel-to-serial driver for daisy-chained LED shift registers (74HC595-style) on the board LED header.
- Captures a WIDTH-bit pattern and shifts it out on led_dat/led_clk with a programmable serial clock rate.
- Selectable bit order and data polarity.
- Offers a start/busy/done handshake and an auto-refresh mode. Replaces the fixed 16-bit, system-clock-rate serializer with its finish-gated clock.
- Sits between switch/register logic and the LED header pins.

Parameters:
WIDTH, 16, number of bits per frame (1..256)
CLK_DIV, 4, system-clock cycles per serial-clock half period (1..65535)
MSB_FIRST, 1, 1 = data[WIDTH-1] shifted first, 0 = data[0] first
ACTIVE_LOW, 1, 1 = led_dat carries inverted data bits (LED lit by 0)

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  synchronous active-high reset
start  input  1  one-cycle request to send a frame; ignored while busy
auto_en  input  1  when 1, a new frame starts automatically after each done
data  input  WIDTH  pattern to display; sampled only at frame start
led_clk  output  1  serial clock to shift register; idles high; device samples on rising edge
led_dat  output  1  serial data; changes only while led_clk is low
led_clr  output  1  active-low clear to shift register
led_en  output  1  output enable to shift register
busy  output  1  high from frame start through the last HIGH phase
done  output  1  one-cycle pulse after the last bit's HIGH phase

Behaviour:
- All outputs are registered.
- Reset values: led_clk=1, led_dat=0, led_clr=0, led_en=0, busy=0, done=0, state=IDLE, counters=0.
- The cycle after reset deasserts: led_clr=1 and led_en=1, held constant thereafter.
- FSM states: IDLE, LOW, HIGH, DONE.
- IDLE -> LOW when (start | auto_en) on a clk edge. In the same edge:
  - shadow <= data
  - bit_cnt <= 0
  - div_cnt <= 0
  - busy <= 1
  - led_clk <= 0
  - led_dat <= first bit (XOR ACTIVE_LOW)
- LOW: hold for CLK_DIV cycles, then -> HIGH; led_clk <= 1 (device rising edge).
- HIGH: hold for CLK_DIV cycles, then:
  - if bit_cnt == WIDTH-1 -> DONE; led_clk stays 1.
  - else bit_cnt++, -> LOW; led_clk <= 0, led_dat <= next bit.
- DONE: one cycle. done=1, busy=0, led_clk=1, then -> IDLE.
  - If auto_en=1 in DONE, the next edge behaves as IDLE with a request: back-to-back frames with exactly one idle cycle between them.
- Bit selection:
  - MSB_FIRST=1: bit index WIDTH-1-bit_cnt.
  - MSB_FIRST=0: bit index bit_cnt.
  - Implemented as a shift of shadow, not a wide mux.
- Timing:
  - Latency start edge -> first led_clk fall: 1 cycle.
  - Frame length: WIDTH*2*CLK_DIV cycles of busy, then 1 done cycle.
  - Exactly WIDTH rising edges of led_clk per frame.
- Counter widths: div_cnt is $clog2(CLK_DIV+1) bits and wraps to 0 at each phase change; bit_cnt is $clog2(WIDTH+1) bits.
- Boundary conditions:
  - start while busy or in DONE: ignored; no queuing.
  - start and auto_en together: a single frame start.
  - data changes mid-frame: no effect; the shadow copy is used.
  - WIDTH=1: one LOW/HIGH pair, then DONE.
  - CLK_DIV=1: led_clk toggles every cycle.
  - rst mid-frame: next edge enters the reset values. led_clk returns high, the partial frame is abandoned, and no done pulse is issued.
  - led_clr=0 during reset clears the external register.

Decomposition:
- Shared package led_pkg holds:
  - typedef enum led_p2s_state_t {IDLE, LOW, HIGH, DONE}
  - localparam defaults LED_WIDTH_DEF=16 and LED_CLK_DIV_DEF=4, shared with display top levels.
- One natural sub-module: led_phase_timer (parameter CLK_DIV; ports clk, rst, restart, expire). It counts CLK_DIV cycles per phase and is reused for both LOW and HIGH.

Test Plan:
- WIDTH=16, CLK_DIV=2, MSB_FIRST=1, ACTIVE_LOW=1, data=16'hA5C3, start pulse at cycle 0 -> 16 led_clk rising edges; bits sampled at the rises read 16'h5A3C MSB first; busy high cycles 1..64; done=1 at cycle 65 only.
- Same with MSB_FIRST=0, ACTIVE_LOW=0, data=16'h0001 -> first sampled bit 1, remaining 15 bits 0; led_dat stable across every rising edge.
- auto_en=1 held, data changes from 16'hFFFF to 16'h0000 during frame 1 -> frame 1 sends all ones, frame 2 all zeros; exactly one IDLE cycle with led_clk=1 between the frames.
- start re-pulsed at cycles 10 and 30 of a frame -> ignored; still exactly 16 rising edges and one done pulse.
- rst asserted at cycle 20 of a frame for 1 cycle -> next cycle led_clk=1, led_dat=0, busy=0, led_clr=0, led_en=0; no done pulse; led_clr=1 and led_en=1 one cycle after rst drops; a new start sends a complete frame.
- WIDTH=1, CLK_DIV=1, data=1'b1, ACTIVE_LOW=1 -> led_clk low 1 cycle, high 1 cycle, led_dat=0 at the rise, done at cycle 3.
